imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 256, instruction memory depth in 32-bit words (power of two).
REQ-002 Parameter AW, default 8, word address width, log2(DEPTH).
REQ-003 i_clk  input  1  clock; all state changes on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_ld_start  input  1  one-cycle pulse requesting a program load.
REQ-006 i_ld_len  input  AW+1  number of words to load; sampled on i_ld_start.
REQ-007 i_ld_valid  input  1  loader word valid.
REQ-008 i_ld_data  input  32  loader word.
REQ-009 o_ld_ready  output  1  block accepts a loader word this cycle.
REQ-010 i_run_start  input  1  one-cycle pulse requesting re-execution of the loaded program, no reload.
REQ-011 i_max_cycles  input  32  run-cycle budget; 0 = unlimited; sampled on entry to BOOT.
REQ-012 i_core_pc  input  32  core fetch address, word index (core increments by 1).
REQ-013 o_core_inst  output  32  instruction returned to core, combinational from i_core_pc.
REQ-014 o_core_rst  output  1  reset to core, registered.
REQ-015 o_state  output  3  IDLE=0, LOAD=1, BOOT=2, RUN=3, HALT=4.
REQ-016 o_cycles  output  32  RUN cycles elapsed in current/last run.
REQ-017 o_halted, o_timeout, o_err  output  1 each  halt-instruction stop, budget stop, bad load length.

Function
REQ-018 Block SHALL own a DEPTH x 32 memory: one write port (loader), one asynchronous read port (core).
REQ-019 IDLE: i_ld_start with 1 <= i_ld_len <= DEPTH -> LOAD, write pointer = 0, o_err = 0; length 0 or > DEPTH -> stay IDLE, o_err = 1.
REQ-020 IDLE or HALT: i_run_start -> BOOT; i_ld_start and i_run_start in same cycle -> i_ld_start wins.
REQ-021 LOAD: o_ld_ready = 1; each cycle with i_ld_valid = 1 writes i_ld_data to mem[pointer], pointer += 1.
REQ-022 LOAD: cycle accepting word i_ld_len-1 -> BOOT next cycle; o_ld_ready = 0 in all other states.
REQ-023 LOAD: i_ld_start and i_run_start ignored; valid gaps stall with no write.
REQ-024 BOOT: lasts exactly one cycle; o_cycles cleared, o_halted/o_timeout cleared, budget latched -> RUN.
REQ-025 o_core_rst SHALL be 1 in IDLE, LOAD, BOOT, HALT and 0 only in RUN (registered, tracks o_state).
REQ-026 RUN: o_core_inst = mem[i_core_pc[AW-1:0]] if i_core_pc < DEPTH, else 32'h00000013 (NOP).
REQ-027 Non-RUN states: o_core_inst = 32'h00000013.
REQ-028 RUN: o_cycles += 1 every cycle, saturating at 32'hFFFFFFFF.
REQ-029 RUN: o_core_inst == 32'h0000006F (jal x0,0) -> HALT next cycle, o_halted = 1.
REQ-030 RUN: latched budget nonzero and o_cycles == budget-1 this cycle -> HALT next cycle, o_timeout = 1.
REQ-031 Halt and timeout in same cycle: o_halted = 1, o_timeout = 0.
REQ-032 HALT: o_cycles, o_halted, o_timeout held until next BOOT or LOAD; i_ld_start -> LOAD clears o_halted/o_timeout.
REQ-033 Memory contents SHALL not be cleared by i_rst; loaded program survives reset.

Reset
REQ-034 i_rst = 1 at any point, including mid-LOAD or mid-RUN: next cycle o_state = IDLE, o_core_rst = 1, o_ld_ready = 0, o_cycles = 0, o_halted = o_timeout = o_err = 0, write pointer = 0.
REQ-035 Partial load interrupted by reset: words already written remain; no further writes.

Verification
REQ-036 Load 3 words {addi x1,x0,5; addi x2,x1,1; 32'h0000006F}, valid every cycle -> o_ld_ready high 3 cycles, BOOT 1 cycle, RUN; o_halted = 1 with o_cycles = 3, o_core_rst = 1 in HALT.
REQ-037 Load 2 words with valid gap of 2 cycles between them -> exactly 2 writes, LOAD lasts 4 cycles, then BOOT.
REQ-038 Program looping without jal x0,0, i_max_cycles = 10 -> HALT after exactly 10 RUN cycles, o_timeout = 1, o_cycles = 10.
REQ-039 i_ld_start with i_ld_len = 0, then DEPTH+1 -> o_err = 1, o_state stays IDLE, no writes.
REQ-040 i_rst mid-RUN, then i_run_start -> IDLE, then BOOT, RUN re-executes unchanged program to same o_halted/o_cycles result.
REQ-041 i_core_pc = DEPTH during RUN -> o_core_inst = 32'h00000013.

Source files
------------

// File: rtl/imem_loader_if.sv
// Loader-side word stream into the instruction memory.
// Valid/ready: a word transfers on a rising edge where ld_valid and ld_ready are both high; ld_valid may drop at any time (a gap).
interface imem_loader_if #(
  parameter int AW = 8
) ();
  logic          ld_start;
  logic [AW:0]   ld_len;
  logic          ld_valid;
  logic [31:0]   ld_data;
  logic          ld_ready;

  modport master (
    output ld_start, ld_len, ld_valid, ld_data,
    input  ld_ready
  );

  modport slave (
    input  ld_start, ld_len, ld_valid, ld_data,
    output ld_ready
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory with a loader port, a boot sequencer holding the core in reset,
// and a run monitor that stops on a self-jump or an exhausted cycle budget.
module imem_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  imem_loader_if.slave ld,
  input  logic        run_start,
  input  logic [31:0] max_cycles,
  input  logic [31:0] core_pc,
  output logic [31:0] core_inst,
  output logic        core_rst,
  output logic [2:0]  state,
  output logic [31:0] cycles,
  output logic        halted,
  output logic        timeout,
  output logic        err
);

  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam logic [31:0] HALT_INST = 32'h0000_006F;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_BOOT = 3'd2,
    S_RUN  = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t      st, nxt;
  logic [31:0] mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] len_q;
  logic [31:0] budget;

  logic len_ok, start_req, wr_en, last_word, hit_halt, hit_budget;

  assign state    = st;
  assign ld.ld_ready = (st == S_LOAD);

  assign len_ok    = (ld.ld_len != '0) && (ld.ld_len <= (AW+1)'(DEPTH));
  assign start_req = ((st == S_IDLE) || (st == S_HALT)) && ld.ld_start;
  assign wr_en     = (st == S_LOAD) && ld.ld_valid;
  assign last_word = wr_en && (wptr == len_q - (AW+1)'(1));

  // The core only sees memory while running; out-of-range fetches return a NOP.
  assign core_inst = ((st == S_RUN) && (core_pc < 32'(DEPTH))) ? mem[core_pc[AW-1:0]] : NOP_INST;

  assign hit_halt   = (st == S_RUN) && (core_inst == HALT_INST);
  assign hit_budget = (st == S_RUN) && (budget != '0) && (cycles == budget - 32'd1);

  always_comb begin
    nxt = st;
    case (st)
      S_IDLE, S_HALT: begin
        // A load request always takes precedence over a run request, even a rejected one.
        if (ld.ld_start) begin
          if (len_ok) nxt = S_LOAD;
        end else if (run_start) begin
          nxt = S_BOOT;
        end
      end
      S_LOAD:  if (last_word) nxt = S_BOOT;
      S_BOOT:  nxt = S_RUN;
      S_RUN:   if (hit_halt || hit_budget) nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st       <= S_IDLE;
      core_rst <= 1'b1;
      wptr     <= '0;
      len_q    <= '0;
      budget   <= '0;
      cycles   <= '0;
      halted   <= 1'b0;
      timeout  <= 1'b0;
      err      <= 1'b0;
    end else begin
      st       <= nxt;
      core_rst <= (nxt != S_RUN);

      if (start_req) begin
        if (len_ok) begin
          wptr    <= '0;
          len_q   <= ld.ld_len;
          err     <= 1'b0;
          cycles  <= '0;
          halted  <= 1'b0;
          timeout <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end

      if (wr_en) wptr <= wptr + (AW+1)'(1);

      if ((nxt == S_BOOT) && (st != S_BOOT)) budget <= max_cycles;

      if (st == S_BOOT) begin
        cycles  <= '0;
        halted  <= 1'b0;
        timeout <= 1'b0;
      end

      if (st == S_RUN) begin
        if (cycles != '1) cycles <= cycles + 32'd1;
        // A self-jump outranks the budget when both land on the same cycle.
        if (hit_halt)        halted  <= 1'b1;
        else if (hit_budget) timeout <= 1'b1;
      end
    end
  end

  // Program storage is deliberately outside reset so a loaded image survives it.
  always_ff @(posedge i_clk) begin
    if (!i_rst && wr_en) mem[wptr[AW-1:0]] <= ld.ld_data;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a driver pushes expected observations stamped with a cycle,
// and a negedge monitor pops and compares them.
module tb_imem_loader;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int W     = 72;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] W0   = 32'h0050_0093;
  localparam logic [31:0] W1   = 32'h0010_8113;
  localparam logic [31:0] WA   = 32'h00A0_0093;
  localparam logic [31:0] WB   = 32'h0010_8093;
  localparam logic [31:0] WX   = 32'h0070_0093;

  localparam logic [W-1:0] M_ALL    = '1;
  localparam logic [W-1:0] M_NO_CYC = ~(72'hFFFF_FFFF << 3);
  localparam logic [W-1:0] M_NO_ERR = ~72'h1;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        run_start;
  logic [31:0] max_cycles, core_pc, core_inst, cycles;
  logic        core_rst, halted, timeout, err;
  logic [2:0]  state;

  always #5 i_clk = ~i_clk;

  imem_loader_if #(.AW(AW)) ld_if ();

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .ld         (ld_if.slave),
    .run_start  (run_start),
    .max_cycles (max_cycles),
    .core_pc    (core_pc),
    .core_inst  (core_inst),
    .core_rst   (core_rst),
    .state      (state),
    .cycles     (cycles),
    .halted     (halted),
    .timeout    (timeout),
    .err        (err)
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  int           stamp_q[$];
  string        name_q[$];
  int cyc_cnt = 0;
  int n_vec   = 0;
  int n_miss  = 0;

  always @(posedge i_clk) cyc_cnt++;

  // Monitor: compares every observation whose cycle stamp has come due.
  always @(negedge i_clk) begin
    logic [W-1:0] got, e, m;
    int           s;
    string        nm;
    got = {state, ld_if.ld_ready, core_rst, core_inst, cycles, halted, timeout, err};
    while (stamp_q.size() > 0 && stamp_q[0] <= cyc_cnt) begin
      e  = exp_q.pop_front();
      m  = mask_q.pop_front();
      s  = stamp_q.pop_front();
      nm = name_q.pop_front();
      n_vec++;
      if ((((got ^ e) & m) != '0) || (s != cyc_cnt)) begin
        n_miss++;
        $display("FAIL %s: got st=%0d rdy=%0b crst=%0b inst=%h cyc=%0d h=%0b t=%0b e=%0b, want st=%0d rdy=%0b crst=%0b inst=%h cyc=%0d h=%0b t=%0b e=%0b",
                 nm, got[71:69], got[68], got[67], got[66:35], got[34:3], got[2], got[1], got[0],
                 e[71:69], e[68], e[67], e[66:35], e[34:3], e[2], e[1], e[0]);
      end
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic expect_v(input string nm, input logic [2:0] st, input logic rdy, input logic crst,
                          input logic [31:0] inst, input logic [31:0] cyc, input logic h,
                          input logic t, input logic e, input logic [W-1:0] m);
    exp_q.push_back({st, rdy, crst, inst, cyc, h, t, e});
    mask_q.push_back(m);
    stamp_q.push_back(cyc_cnt);
    name_q.push_back(nm);
  endtask

  // Runs a three-word program whose third word is the self-jump, starting in BOOT.
  task automatic run_prog(input string nm, input logic [31:0] a, input logic [31:0] b, input logic [W-1:0] m);
    step(); core_pc = 32'd0; expect_v({nm, "_pc0"}, 3'd3, 1'b0, 1'b0, a,   32'd0, 1'b0, 1'b0, 1'b0, m);
    step(); core_pc = 32'd1; expect_v({nm, "_pc1"}, 3'd3, 1'b0, 1'b0, b,   32'd1, 1'b0, 1'b0, 1'b0, m);
    step(); core_pc = 32'd2; expect_v({nm, "_pc2"}, 3'd3, 1'b0, 1'b0, JAL, 32'd2, 1'b0, 1'b0, 1'b0, m);
    step();                  expect_v({nm, "_halt"}, 3'd4, 1'b0, 1'b1, NOP, 32'd3, 1'b1, 1'b0, 1'b0, m);
  endtask

  int pcs [10] = '{0, 1, 0, 1, 0, DEPTH, 1, 0, 1, 0};

  initial begin
    logic [31:0] want;
    i_rst = 1'b1;
    ld_if.ld_start = 1'b0; ld_if.ld_len = '0; ld_if.ld_valid = 1'b0; ld_if.ld_data = '0;
    run_start = 1'b0; max_cycles = 32'd0; core_pc = 32'd0;
    step(); step();
    expect_v("reset", 3'd0, 1'b0, 1'b1, NOP, 32'd0, 1'b0, 1'b0, 1'b0, M_ALL);

    // Three-word program, valid every cycle, ends on the self-jump.
    i_rst = 1'b0; ld_if.ld_start = 1'b1; ld_if.ld_len = 9'd3;
    step(); ld_if.ld_start = 1'b0; ld_if.ld_valid = 1'b1; ld_if.ld_data = W0;
    expect_v("load3_w0", 3'd1, 1'b1, 1'b1, NOP, 32'd0, 1'b0, 1'b0, 1'b0, M_ALL);
    step(); ld_if.ld_data = W1;
    expect_v("load3_w1", 3'd1, 1'b1, 1'b1, NOP, 32'd0, 1'b0, 1'b0, 1'b0, M_ALL);
    step(); ld_if.ld_data = JAL;
    expect_v("load3_w2", 3'd1, 1'b1, 1'b1, NOP, 32'd0, 1'b0, 1'b0, 1'b0, M_ALL);
    step(); ld_if.ld_valid = 1'b0;
    expect_v("load3_boot", 3'd2, 1'b0, 1'b1, NOP, 32'd0, 1'b0, 1'b0, 1'b0, M_ALL);
    run_prog("run1", W0, W1, M_ALL);

    // Two words with a two-cycle valid gap, then a 10-cycle budget timeout.
    ld_if.ld_start = 1'b1; ld_if.ld_len = 9'd2; max_cycles = 32'd10;
    step(); ld_if.ld_start = 1'b0; ld_if.ld_valid = 1'b1; ld_if.ld_data = WA;
    expect_v("load2_c0", 3'd1, 1'b1, 1'b1, NOP, 32'd0, 1'b0, 1'b0, 1'b0, M_NO_CYC);
    step(); ld_if.ld_valid = 1'b0;
    expect_v("load2_gap1", 3'd1, 1'b1, 1'b1, NOP, 32'd0, 1'b0, 1'b0, 1'b0, M_NO_CYC);
    step();
    expect_v("load2_gap2", 3'd1, 1'b1, 1'b1, NOP, 32'd0, 1'b0, 1'b0, 1'b0, M_NO_CYC);
    step(); ld_if.ld_valid = 1'b1; ld_if.ld_data = WB;
    expect_v("load2_c3", 3'd1, 1'b1, 1'b1, NOP, 32'd0, 1'b0, 1'b0, 1'b0, M_NO_CYC);
    step(); ld_if.ld_valid = 1'b0;
    expect_v("load2_boot", 3'd2, 1'b0, 1'b1, NOP, 32'd0, 1'b0, 1'b0, 1'b0, M_NO_CYC);
    for (int k = 0; k < 10; k++) begin
      step(); core_pc = 32'(pcs[k]);
      want = (pcs[k] == 0) ? WA : ((pcs[k] == 1) ? WB : NOP);
      expect_v($sformatf("budget_run%0d", k), 3'd3, 1'b0, 1'b0, want, 32'(k), 1'b0, 1'b0, 1'b0, M_ALL);
    end
    step();
    expect_v("budget_halt", 3'd4, 1'b0, 1'b1, NOP, 32'd10, 1'b0, 1'b1, 1'b0, M_ALL);

    // Bad lengths, including one racing a run request, leave memory and state alone.
    max_cycles = 32'd0; i_rst = 1'b1;
    step(); i_rst = 1'b0;
    expect_v("rst_from_halt", 3'd0, 1'b0, 1'b1, NOP, 32'd0, 1'b0, 1'b0, 1'b0, M_ALL);
    ld_if.ld_start = 1'b1; ld_if.ld_len = 9'd0; run_start = 1'b1;
    step(); ld_if.ld_start = 1'b0; run_start = 1'b0;
    expect_v("len0_err", 3'd0, 1'b0, 1'b1, NOP, 32'd0, 1'b0, 1'b0, 1'b1, M_ALL);
    ld_if.ld_start = 1'b1; ld_if.ld_len = (AW+1)'(DEPTH + 1);
    step(); ld_if.ld_start = 1'b0;
    expect_v("len257_err", 3'd0, 1'b0, 1'b1, NOP, 32'd0, 1'b0, 1'b0, 1'b1, M_ALL);
    run_start = 1'b1;
    step(); run_start = 1'b0;
    expect_v("err_boot", 3'd2, 1'b0, 1'b1, NOP, 32'd0, 1'b0, 1'b0, 1'b0, M_NO_ERR);
    run_prog("run_noload", WA, WB, M_NO_ERR);

    // Reset in the middle of a run, then a clean re-run of the same image.
    run_start = 1'b1;
    step(); run_start = 1'b0;
    expect_v("rerun_boot", 3'd2, 1'b0, 1'b1, NOP, 32'd3, 1'b1, 1'b0, 1'b0, M_NO_ERR);
    step(); core_pc = 32'd0;
    expect_v("midrun_pc0", 3'd3, 1'b0, 1'b0, WA, 32'd0, 1'b0, 1'b0, 1'b0, M_NO_ERR);
    step(); core_pc = 32'd1; i_rst = 1'b1;
    expect_v("midrun_pc1", 3'd3, 1'b0, 1'b0, WB, 32'd1, 1'b0, 1'b0, 1'b0, M_NO_ERR);
    step(); i_rst = 1'b0;
    expect_v("rst_mid_run", 3'd0, 1'b0, 1'b1, NOP, 32'd0, 1'b0, 1'b0, 1'b0, M_ALL);
    run_start = 1'b1;
    step(); run_start = 1'b0;
    expect_v("after_rst_boot", 3'd2, 1'b0, 1'b1, NOP, 32'd0, 1'b0, 1'b0, 1'b0, M_ALL);
    run_prog("run_after_rst", WA, WB, M_ALL);

    // Reset mid-load keeps the written word and blocks the word presented during reset.
    ld_if.ld_start = 1'b1; ld_if.ld_len = 9'd3;
    step(); ld_if.ld_start = 1'b0; ld_if.ld_valid = 1'b1; ld_if.ld_data = WX;
    expect_v("pload_c0", 3'd1, 1'b1, 1'b1, NOP, 32'd0, 1'b0, 1'b0, 1'b0, M_NO_CYC);
    step(); ld_if.ld_data = 32'hDEAD_BEEF; i_rst = 1'b1;
    expect_v("pload_c1", 3'd1, 1'b1, 1'b1, NOP, 32'd0, 1'b0, 1'b0, 1'b0, M_NO_CYC);
    step(); i_rst = 1'b0; ld_if.ld_valid = 1'b0;
    expect_v("rst_mid_load", 3'd0, 1'b0, 1'b1, NOP, 32'd0, 1'b0, 1'b0, 1'b0, M_ALL);
    run_start = 1'b1;
    step(); run_start = 1'b0;
    expect_v("pload_boot", 3'd2, 1'b0, 1'b1, NOP, 32'd0, 1'b0, 1'b0, 1'b0, M_ALL);
    run_prog("run_partial", WX, WB, M_ALL);

    step(); step();
    if (stamp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: got %0d unchecked entries, want 0", stamp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
